sync_fifo_param: RTL

Parametrised single-clock FIFO, the successor to the fixed 16-bit / 256-deep `sync_fifo` used by the switch queues. It adds:
- configurable width and depth;
- a selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full / almost-empty flags;
- a synchronous flush.

It sits between the packet classifier and the EDF scheduler as the per-queue buffer.

---
 rtl/sync_fifo_param.sv | 115 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with selectable FWFT read mode,
// programmable almost-full/almost-empty flags and synchronous flush.
module sync_fifo_param #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_THRESH  = (1 << DEPTH_LOG2) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  wr_err,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  rd_err,
    output logic [DEPTH_LOG2:0]   data_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [CNT_W-1:0]  count_nxt;

    // Acceptance is judged against the flags before the edge; clr masks both.
    assign wr_acc = wr_en && !full  && !clr;
    assign rd_acc = rd_en && !empty && !clr;

    always_comb begin
        count_nxt = data_count;
        if (clr) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = data_count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = data_count - CNT_W'(1);
        end
    end

    // Flags are registered from the next count so they move with data_count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            wr_err       <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            data_count   <= count_nxt;
            full         <= (count_nxt == CNT_W'(DEPTH));
            almost_full  <= (count_nxt >= CNT_W'(AF_THRESH));
            empty        <= (count_nxt == CNT_W'(0));
            almost_empty <= (count_nxt <= CNT_W'(AE_THRESH));
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                wr_err <= 1'b0;
                rd_err <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                wr_err <= wr_en && full;
                rd_err <= rd_en && empty;
            end
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= mem[rd_ptr];
                    end
                end
            end
        end
    endgenerate

endmodule
